// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared constants and FSM state type for the DDR3 app adapter
package ddr3_app_pkg;

  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         LINE_W     = 512;
  localparam int         BEAT_W     = 256;
  localparam int         APP_ADDR_W = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_e;

endpackage

// File: rtl/ddr3_app_ctrl_if.sv
// rtl/ddr3_app_ctrl_if.sv - request/response and MIG app_* signal bundle
interface ddr3_app_ctrl_if
  import ddr3_app_pkg::*;
#(
  parameter int LINE_ADDR_W = 24
);

  logic                    init_calib_complete;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [LINE_ADDR_W-1:0]  req_addr;
  logic [LINE_W-1:0]       req_data;
  logic [LINE_W/8-1:0]     req_be;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [LINE_W-1:0]       resp_data;
  logic [APP_ADDR_W-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [BEAT_W-1:0]       app_wdf_data;
  logic [BEAT_W/8-1:0]     app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [BEAT_W-1:0]       app_rd_data;
  logic                    app_rd_data_valid;
  logic                    app_rd_data_end;
  logic                    err_sticky;

  // master: requester plus memory side; slave: the adapter itself
  modport master (
    output init_calib_complete, req_valid, req_write, req_addr, req_data, req_be,
    output resp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  req_ready, resp_valid, resp_data, app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, err_sticky
  );

  modport slave (
    input  init_calib_complete, req_valid, req_write, req_addr, req_data, req_be,
    input  resp_ready, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, resp_valid, resp_data, app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, err_sticky
  );

endinterface

// File: rtl/ddr3_resp_fifo.sv
// rtl/ddr3_resp_fifo.sv - synchronous read-line FIFO with registered occupancy count
module ddr3_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 512,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ddr3_app_ctrl.sv
// rtl/ddr3_app_ctrl.sv - 64B line request adapter onto the MIG DDR3 app_* interface
module ddr3_app_ctrl
  import ddr3_app_pkg::*;
#(
  parameter int RESP_DEPTH  = 4,
  parameter int LINE_ADDR_W = 24
) (
  input  logic            ui_clk,
  input  logic            ui_clk_sync_rst,
  ddr3_app_ctrl_if.slave  bus
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  state_e                  state_q;
  logic                    cmd_done_q;
  logic                    data_done_q;
  logic                    beat_sel_q;
  logic [BEAT_W-1:0]       wr_hi_q;
  logic [BEAT_W/8-1:0]     be_hi_q;
  logic [APP_ADDR_W-1:0]   app_addr_q;
  logic [2:0]              app_cmd_q;
  logic                    app_en_q;
  logic [BEAT_W-1:0]       wdf_data_q;
  logic [BEAT_W/8-1:0]     wdf_mask_q;
  logic                    wdf_wren_q;
  logic                    wdf_end_q;
  logic [CW-1:0]           credits_q;
  logic [BEAT_W-1:0]       rd_lo_q;
  logic                    err_q;
  logic [CW-1:0]           fifo_count;

  logic req_ready;
  logic req_fire;
  logic resp_fire;
  logic cmd_fire;
  logic beat_fire;
  logic rd_inc;

  // Credits count reads in flight plus lines parked in the FIFO, so the
  // return path can never overrun it despite having no backpressure.
  assign req_ready = (state_q == ST_IDLE) && bus.init_calib_complete
                     && (credits_q < CW'(RESP_DEPTH));
  assign req_fire  = bus.req_valid && req_ready;
  assign resp_fire = bus.resp_valid && bus.resp_ready;
  assign cmd_fire  = app_en_q && bus.app_rdy;
  assign beat_fire = wdf_wren_q && bus.app_wdf_rdy;
  assign rd_inc    = req_fire && !bus.req_write;

  assign bus.req_ready    = req_ready;
  assign bus.app_addr     = app_addr_q;
  assign bus.app_cmd      = app_cmd_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_data = wdf_data_q;
  assign bus.app_wdf_mask = wdf_mask_q;
  assign bus.app_wdf_wren = wdf_wren_q;
  assign bus.app_wdf_end  = wdf_end_q;
  assign bus.err_sticky   = err_q;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q     <= ST_IDLE;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      beat_sel_q  <= 1'b0;
      wr_hi_q     <= '0;
      be_hi_q     <= '0;
      app_addr_q  <= '0;
      app_cmd_q   <= CMD_WRITE;
      app_en_q    <= 1'b0;
      wdf_data_q  <= '0;
      wdf_mask_q  <= '0;
      wdf_wren_q  <= 1'b0;
      wdf_end_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            app_addr_q <= APP_ADDR_W'({bus.req_addr[LINE_ADDR_W-1:0], 3'b000});
            app_en_q   <= 1'b1;
            if (bus.req_write) begin
              state_q     <= ST_WRITE;
              app_cmd_q   <= CMD_WRITE;
              wdf_wren_q  <= 1'b1;
              wdf_end_q   <= 1'b0;
              wdf_data_q  <= bus.req_data[BEAT_W-1:0];
              wdf_mask_q  <= ~bus.req_be[BEAT_W/8-1:0];
              wr_hi_q     <= bus.req_data[LINE_W-1:BEAT_W];
              be_hi_q     <= bus.req_be[LINE_W/8-1:BEAT_W/8];
              cmd_done_q  <= 1'b0;
              data_done_q <= 1'b0;
              beat_sel_q  <= 1'b0;
            end else begin
              state_q   <= ST_READ;
              app_cmd_q <= CMD_READ;
            end
          end
        end
        ST_WRITE: begin
          if (cmd_fire) begin
            app_en_q   <= 1'b0;
            cmd_done_q <= 1'b1;
          end
          if (beat_fire) begin
            if (!beat_sel_q) begin
              beat_sel_q <= 1'b1;
              wdf_data_q <= wr_hi_q;
              wdf_mask_q <= ~be_hi_q;
              wdf_end_q  <= 1'b1;
            end else begin
              wdf_wren_q  <= 1'b0;
              wdf_end_q   <= 1'b0;
              data_done_q <= 1'b1;
            end
          end
          // Command and data channels finish independently; leave once both have.
          if ((cmd_done_q || cmd_fire) && (data_done_q || (beat_fire && beat_sel_q)))
            state_q <= ST_IDLE;
        end
        ST_READ: begin
          if (cmd_fire) begin
            app_en_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rd_lo_q   <= '0;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (bus.app_rd_data_valid && !bus.app_rd_data_end) rd_lo_q <= bus.app_rd_data;
      case ({rd_inc, resp_fire})
        2'b10:   credits_q <= credits_q + CW'(1);
        2'b01:   credits_q <= credits_q - CW'(1);
        default: credits_q <= credits_q;
      endcase
      if (bus.app_rd_data_valid && (credits_q == fifo_count)) err_q <= 1'b1;
    end
  end

  ddr3_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (LINE_W)
  ) u_resp_fifo (
    .clk_i       (ui_clk),
    .rst_i       (ui_clk_sync_rst),
    .push_i      (bus.app_rd_data_valid && bus.app_rd_data_end),
    .push_data_i ({bus.app_rd_data, rd_lo_q}),
    .pop_i       (resp_fire),
    .head_o      (bus.resp_data),
    .valid_o     (bus.resp_valid),
    .count_o     (fifo_count)
  );

endmodule
